scr1_dmem_router: RTL and testbench

Data-memory router placed directly downstream of the core's data memory interface. It decodes each core dmem request by address and steers it to one of two target ports: port 0 (TCM/default) or port 1 (memory-mapped peripheral region). It tracks which port owns the single outstanding transaction and returns that port's response and read data to the core. One transaction is in flight at a time. A new request may issue in the same cycle the previous response completes.

---
 rtl/scr1_dmem_router_pkg.sv | 33 +++
 rtl/scr1_dmem_router_if.sv | 25 ++
 rtl/scr1_dmem_router.sv | 87 ++++++++
 tb/tb_scr1_dmem_router.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/scr1_dmem_router_pkg.sv
// Shared memif types for the data-memory router: command/width/response enums,
// bus widths, router FSM states and default port-1 decode constants.
package scr1_dmem_router_pkg;

  localparam int SCR1_DMEM_AWIDTH = 32;
  localparam int SCR1_DMEM_DWIDTH = 32;

  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;

  typedef enum logic {
    SCR1_FSM_ADDR = 1'b0,
    SCR1_FSM_DATA = 1'b1
  } type_scr1_dmem_router_fsm_e;

  localparam logic [SCR1_DMEM_AWIDTH-1:0] SCR1_DMEM_ROUTER_PORT1_MASK    = 32'hFFFF_0000;
  localparam logic [SCR1_DMEM_AWIDTH-1:0] SCR1_DMEM_ROUTER_PORT1_PATTERN = 32'h00F0_0000;

endpackage

// File: rtl/scr1_dmem_router_if.sv
// Data-memory request/response bus. The master issues requests and consumes
// responses; the slave accepts requests and returns responses.
interface scr1_dmem_router_if;
  import scr1_dmem_router_pkg::*;

  logic                        req;
  type_scr1_mem_cmd_e          cmd;
  type_scr1_mem_width_e        width;
  logic [SCR1_DMEM_AWIDTH-1:0] addr;
  logic [SCR1_DMEM_DWIDTH-1:0] wdata;
  logic                        req_ack;
  logic [SCR1_DMEM_DWIDTH-1:0] rdata;
  type_scr1_mem_resp_e         resp;

  modport master (
    output req, cmd, width, addr, wdata,
    input  req_ack, rdata, resp
  );

  modport slave (
    input  req, cmd, width, addr, wdata,
    output req_ack, rdata, resp
  );

endinterface

// File: rtl/scr1_dmem_router.sv
// Steers core dmem requests to port 0 (TCM/default) or port 1 (peripherals) by
// address and returns the owning port's response; one transaction in flight.
module scr1_dmem_router
  import scr1_dmem_router_pkg::*;
#(
  parameter logic [SCR1_DMEM_AWIDTH-1:0] PORT1_ADDR_MASK    = SCR1_DMEM_ROUTER_PORT1_MASK,
  parameter logic [SCR1_DMEM_AWIDTH-1:0] PORT1_ADDR_PATTERN = SCR1_DMEM_ROUTER_PORT1_PATTERN
) (
  input  logic                 clk,
  input  logic                 rst_n,
  scr1_dmem_router_if.slave    dmem,
  scr1_dmem_router_if.master   port0,
  scr1_dmem_router_if.master   port1
);

   type_scr1_dmem_router_fsm_e  state;
   logic                        port_sel_r;
   logic                        sel;
   logic                        sel_ack;
   type_scr1_mem_resp_e         sel_resp;
   logic [SCR1_DMEM_DWIDTH-1:0] sel_rdata;
   logic                        can_issue;

   assign sel       = ((dmem.addr & PORT1_ADDR_MASK) == PORT1_ADDR_PATTERN);
   assign sel_ack   = sel        ? port1.req_ack : port0.req_ack;
   assign sel_resp  = port_sel_r ? port1.resp    : port0.resp;
   assign sel_rdata = port_sel_r ? port1.rdata   : port0.rdata;

   // A new request may go out when idle, or in the cycle the owner completes OK.
   assign can_issue = (state == SCR1_FSM_ADDR) || (sel_resp == SCR1_MEM_RESP_RDY_OK);

   assign port0.cmd   = dmem.cmd;
   assign port0.width = dmem.width;
   assign port0.addr  = dmem.addr;
   assign port0.wdata = dmem.wdata;
   assign port1.cmd   = dmem.cmd;
   assign port1.width = dmem.width;
   assign port1.addr  = dmem.addr;
   assign port1.wdata = dmem.wdata;

   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      dmem.resp    = SCR1_MEM_RESP_NOTRDY;
      dmem.rdata   = '0;
      port0.req    = 1'b0;
      port1.req    = 1'b0;
      dmem.req_ack = 1'b0;
      if (state == SCR1_FSM_DATA) begin
         dmem.resp  = sel_resp;
         dmem.rdata = sel_rdata;
      end
      if (can_issue) begin
         port0.req    = dmem.req & ~sel;
         port1.req    = dmem.req &  sel;
         dmem.req_ack = dmem.req &  sel_ack;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= SCR1_FSM_ADDR;
         port_sel_r <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so state and port_sel_r update together at the edge.
         case (state)
            SCR1_FSM_ADDR: begin
               if (dmem.req_ack) begin
                  port_sel_r <= sel;
                  state      <= SCR1_FSM_DATA;
               end
            end
            SCR1_FSM_DATA: begin
               case (sel_resp)
                  SCR1_MEM_RESP_RDY_OK: begin
                     if (dmem.req_ack) port_sel_r <= sel;
                     else              state      <= SCR1_FSM_ADDR;
                  end
                  SCR1_MEM_RESP_RDY_ER: state <= SCR1_FSM_ADDR;
                  default:              state <= SCR1_FSM_DATA;
               endcase
            end
            default: state <= SCR1_FSM_ADDR;
         endcase
      end
   end

endmodule

// File: tb/tb_scr1_dmem_router.sv
// Self-checking bench for scr1_dmem_router: directed scenarios followed by
// randomized traffic, compared against a transaction-owner reference model.
module tb_scr1_dmem_router;
   import scr1_dmem_router_pkg::*;

   localparam logic [31:0] MASK = 32'hFFFF_0000;
   localparam logic [31:0] PAT  = 32'h00F0_0000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   scr1_dmem_router_if core_if ();
   scr1_dmem_router_if p0_if ();
   scr1_dmem_router_if p1_if ();

   scr1_dmem_router #(.PORT1_ADDR_MASK(MASK), .PORT1_ADDR_PATTERN(PAT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .dmem  (core_if),
      .port0 (p0_if),
      .port1 (p1_if)
   );

   typedef struct {
      logic                 req;
      type_scr1_mem_cmd_e   cmd;
      type_scr1_mem_width_e width;
      logic [31:0]          addr;
      logic [31:0]          wdata;
      logic                 ack0, ack1;
      type_scr1_mem_resp_e  r0, r1;
      logic [31:0]          d0, d1;
   } stim_t;

   int vectors = 0;
   int errors  = 0;
   int owner   = -1;  // port owning the outstanding transaction, -1 = none

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic stim_t idle();
      stim_t s;
      s.req = 1'b0; s.cmd = SCR1_MEM_CMD_RD; s.width = SCR1_MEM_WIDTH_WORD;
      s.addr = 32'h0; s.wdata = $urandom;
      s.ack0 = 1'b0; s.ack1 = 1'b0;
      s.r0 = SCR1_MEM_RESP_NOTRDY; s.r1 = SCR1_MEM_RESP_NOTRDY;
      s.d0 = $urandom; s.d1 = $urandom;
      return s;
   endfunction

   function automatic stim_t rq(input logic [31:0] a, input type_scr1_mem_cmd_e c);
      stim_t s = idle();
      s.req = 1'b1; s.addr = a; s.cmd = c;
      return s;
   endfunction

   task automatic drive(input stim_t s);
      core_if.req = s.req; core_if.cmd = s.cmd; core_if.width = s.width;
      core_if.addr = s.addr; core_if.wdata = s.wdata;
      p0_if.req_ack = s.ack0; p0_if.resp = s.r0; p0_if.rdata = s.d0;
      p1_if.req_ack = s.ack1; p1_if.resp = s.r1; p1_if.rdata = s.d1;
   endtask

   // One clock: apply stimulus, compare against the model, then retire the edge.
   task automatic cycle(input stim_t s, output logic acked);
      int                  tgt;
      logic                free;
      type_scr1_mem_resp_e e_resp;
      logic [31:0]         e_rdata;
      logic                e_ack;
      @(negedge clk);
      drive(s);
      #1;
      tgt     = ((s.addr & MASK) == PAT) ? 1 : 0;
      e_resp  = (owner < 0) ? SCR1_MEM_RESP_NOTRDY : (owner == 1 ? s.r1 : s.r0);
      e_rdata = (owner < 0) ? 32'h0 : (owner == 1 ? s.d1 : s.d0);
      free    = (owner < 0) || (e_resp == SCR1_MEM_RESP_RDY_OK);
      e_ack   = free && s.req && (tgt == 1 ? s.ack1 : s.ack0);
      check("dmem_resp",  64'(core_if.resp),    64'(e_resp));
      check("dmem_rdata", 64'(core_if.rdata),   64'(e_rdata));
      check("req_ack",    64'(core_if.req_ack), 64'(e_ack));
      check("port0_req",  64'(p0_if.req),       64'(free && s.req && tgt == 0));
      check("port1_req",  64'(p1_if.req),       64'(free && s.req && tgt == 1));
      check("bcast",      {p0_if.addr, p1_if.wdata}, {s.addr, s.wdata});
      check("bcast_ctl",  64'({p1_if.cmd, p0_if.width}), 64'({s.cmd, s.width}));
      @(posedge clk);
      if (e_ack)                                           owner = tgt;
      else if (owner >= 0 && e_resp != SCR1_MEM_RESP_NOTRDY) owner = -1;
      acked = e_ack;
   endtask

   initial begin
      stim_t s;
      stim_t pend;
      logic  has_pend;
      logic  a;

      drive(idle());
      #2;
      check("rst_resp",  64'(core_if.resp),    64'(SCR1_MEM_RESP_NOTRDY));
      check("rst_rdata", 64'(core_if.rdata),   64'h0);
      check("rst_ack",   64'(core_if.req_ack), 64'h0);
      @(negedge clk); rst_n = 1'b1;

      // Port 0 read, immediate ack, data next cycle.
      s = rq(32'h0000_0100, SCR1_MEM_CMD_RD); s.ack0 = 1'b1; cycle(s, a);
      s = idle(); s.r0 = SCR1_MEM_RESP_RDY_OK; s.d0 = 32'hDEAD_BEEF; cycle(s, a);
      s = idle(); s.r0 = SCR1_MEM_RESP_RDY_OK; cycle(s, a);

      // Port 1 write, ack stalled 3 cycles, then NOTRDY x2, then RDY_OK.
      for (int i = 0; i < 4; i++) begin
         s = rq(32'h00F0_0008, SCR1_MEM_CMD_WR); s.ack1 = (i == 3); cycle(s, a);
      end
      for (int i = 0; i < 3; i++) begin
         s = idle(); s.r1 = (i == 2) ? SCR1_MEM_RESP_RDY_OK : SCR1_MEM_RESP_NOTRDY; cycle(s, a);
      end

      // Back-to-back port0 -> port1 with no bubble.
      s = rq(32'h0000_0040, SCR1_MEM_CMD_RD); s.ack0 = 1'b1; cycle(s, a);
      s = rq(32'h00F0_0000, SCR1_MEM_CMD_RD); s.ack1 = 1'b1; s.r0 = SCR1_MEM_RESP_RDY_OK; cycle(s, a);
      check("b2b_acked", 64'(a), 64'h1);
      s = idle(); s.r1 = SCR1_MEM_RESP_RDY_OK; s.r0 = SCR1_MEM_RESP_RDY_ER; cycle(s, a);

      // Port1 error with a request pending: no issue until the next cycle.
      s = rq(32'h00F0_0004, SCR1_MEM_CMD_RD); s.ack1 = 1'b1; cycle(s, a);
      s = rq(32'h0000_0200, SCR1_MEM_CMD_RD); s.ack0 = 1'b1; s.r1 = SCR1_MEM_RESP_RDY_ER; cycle(s, a);
      check("err_no_issue", 64'(a), 64'h0);
      s = rq(32'h0000_0200, SCR1_MEM_CMD_RD); s.ack0 = 1'b1; cycle(s, a);
      check("err_reissue", 64'(a), 64'h1);
      s = idle(); s.r0 = SCR1_MEM_RESP_RDY_OK; cycle(s, a);

      // Spurious response in ADDR.
      s = idle(); s.r0 = SCR1_MEM_RESP_RDY_OK; s.d0 = 32'h1234_5678; cycle(s, a);

      // Reset while awaiting port1; the late response is dropped.
      s = rq(32'h00F0_0010, SCR1_MEM_CMD_RD); s.ack1 = 1'b1; cycle(s, a);
      @(negedge clk);
      s = idle(); s.r1 = SCR1_MEM_RESP_RDY_OK; s.d1 = 32'hCAFE_F00D; drive(s);
      #1;
      check("pre_rst_resp", 64'(core_if.resp), 64'(SCR1_MEM_RESP_RDY_OK));
      rst_n = 1'b0;
      #1;
      check("mid_rst_resp",  64'(core_if.resp),  64'(SCR1_MEM_RESP_NOTRDY));
      check("mid_rst_rdata", 64'(core_if.rdata), 64'h0);
      owner = -1;
      @(negedge clk); rst_n = 1'b1;
      s = idle(); s.r1 = SCR1_MEM_RESP_RDY_OK; s.d1 = 32'hCAFE_F00D; cycle(s, a);

      // Randomized traffic; a pending request is held stable until acked.
      has_pend = 1'b0;
      pend = idle();
      for (int n = 0; n < 3000; n++) begin
         int rr;
         if (!has_pend && ($urandom_range(0, 3) != 0)) begin
            pend = rq(($urandom_range(0, 1) != 0) ? (PAT | ($urandom & 32'h0000_FFFF)) : $urandom,
                      ($urandom_range(0, 1) != 0) ? SCR1_MEM_CMD_WR : SCR1_MEM_CMD_RD);
            pend.width = type_scr1_mem_width_e'($urandom_range(0, 2));
            has_pend = 1'b1;
         end
         s = has_pend ? pend : idle();
         s.ack0 = $urandom_range(0, 1) != 0;
         s.ack1 = $urandom_range(0, 1) != 0;
         rr = $urandom_range(0, 19);
         s.r0 = (rr < 8) ? SCR1_MEM_RESP_NOTRDY : (rr < 17) ? SCR1_MEM_RESP_RDY_OK : SCR1_MEM_RESP_RDY_ER;
         rr = $urandom_range(0, 19);
         s.r1 = (rr < 8) ? SCR1_MEM_RESP_NOTRDY : (rr < 17) ? SCR1_MEM_RESP_RDY_OK : SCR1_MEM_RESP_RDY_ER;
         s.d0 = $urandom; s.d1 = $urandom;
         cycle(s, a);
         if (a) has_pend = 1'b0;
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
